display_scan_controller: RTL
============================

Name: display_scan_controller

Overview:
Time-multiplexing scan controller for the 4-digit common-anode 7-segment display. It holds a 4-digit BCD word and cycles the digit-select state STAC through 0..3 at a prescaled rate. Between digits it inserts a blanking gap to prevent ghosting. It drives the active-low anode lines and the current BCD nibble to the downstream BCD-to-7-segment decoder.

Parameters:
DIV, 50000, prescaler terminal count; each digit is shown for DIV clock cycles (DIV >= 2).
DEAD, 2, blanking cycles between digits, all anodes off (DEAD >= 1).
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W > DIV.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  scan enable.
LOAD  input  1  single-cycle strobe that captures DIN into the pending register.
DIN  input  16  BCD word; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
LZB  input  1  leading-zero blanking enable.
STAC  output  2  current digit index, 0..3.
AN  output  4  anode enables, active-low one-hot; AN[i] drives digit i.
BCD  output  4  nibble of the currently selected digit.
FRAME  output  1  one-cycle pulse on the cycle the pending word is transferred.
PEND  output  1  pending word loaded but not yet displayed.

Behaviour:
- Reset (async, RST=1): prescaler=0, dead counter=0, state=SHOW, STAC=0, AN=4'b1111, BCD=0, FRAME=0, PEND=0, pending=0, active=0. Reset mid-scan aborts immediately; nothing is retained.
- Buffering:
  - LOAD=1 writes DIN into pending and sets PEND=1.
  - pending is copied to active only at the frame boundary (BLANK exit with STAC 3->0); on that cycle FRAME=1 and PEND clears.
  - If LOAD=1 on the same cycle as a transfer: active gets the old pending, pending gets DIN, PEND stays 1.
  - Multiple LOADs within one frame: the last one wins.
  - If PEND=0 at the boundary, no transfer occurs and FRAME stays 0.
- FSM has two states, SHOW and BLANK.
  - SHOW: the prescaler increments every cycle. When it equals DIV-1: clear it and go to BLANK.
  - BLANK: the dead counter increments every cycle. When it equals DEAD-1: clear it, advance STAC by 1 mod 4 (3 wraps to 0), and go to SHOW.
  - Each digit period is exactly DIV+DEAD cycles. A full frame is 4*(DIV+DEAD) cycles.
- Outputs are registered and reflect the state and counters of the previous cycle. AN, BCD and STAC update together, so there is no glitch window.
  - SHOW: AN = ~(1<<STAC); BCD = active[4*STAC+3 : 4*STAC].
  - BLANK: AN = 4'b1111; BCD holds its last value.
- Leading-zero blanking (LZB=1): digit i (i=3,2,1) is forced to AN[i]=1 while in SHOW if nibbles i..3 of active are all zero. Digit 0 is never blanked. Timing and STAC advance are unaffected.
- Nibbles >9 pass through unchanged; the decoder owns their mapping.
- EN=0:
  - AN=4'b1111.
  - Prescaler and dead counter are cleared; state forced to SHOW; STAC holds.
  - LOAD is still accepted, and transfer still occurs as described below.
- EN 0->1: the current STAC digit is shown for a full DIV cycles.
- While EN=0 the frame boundary never occurs. Pending transfers into active immediately on the first cycle with EN=0 and PEND=1; FRAME pulses on that cycle.

Test Plan:
- Reset then scan (DIV=4, DEAD=1, EN=1, LOAD DIN=16'h1234):
  - Transfer occurs on the first boundary.
  - Then STAC sequence is 0,1,2,3; per digit, 4 cycles of AN=1110/1101/1011/0111 with BCD=4/3/2/1, followed by 1 cycle of AN=1111.
- Frame buffering: while digit 2 is shown, LOAD 16'h5678.
  - Digits 2 and 3 still show 2 and 1; PEND=1.
  - FRAME pulses at the 3->0 wrap; digit 0 then shows 8; PEND=0.
- Simultaneous LOAD and transfer: pending=16'h1111 and LOAD 16'h2222 on the FRAME cycle.
  - active=1111 and PEND stays 1.
  - Next boundary: active=2222, FRAME pulses.
- Leading-zero blanking: active=16'h0040, LZB=1.
  - AN stays 1111 during the digit 3 and digit 2 slots.
  - Digit 1 shows 4; digit 0 shows 0.
  - With active=16'h0000: only digit 0 lights.
- EN and reset mid-operation:
  - EN=0 at the mid-point of digit 1: AN=1111 next cycle, STAC holds 1.
  - EN=1: digit 1 is shown for a full 4 cycles.
  - Assert RST mid-BLANK: all outputs at reset values immediately, asynchronously, and PEND is lost.

Source files
------------

// File: rtl/display_scan_controller_if.sv
// Bus between a host and the 4-digit display scan controller: load/enable
// controls in, the digit select, anode, nibble and status lines out.
interface display_scan_controller_if;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic        lzb;
  logic [1:0]  stac;
  logic [3:0]  an;
  logic [3:0]  bcd;
  logic        frame;
  logic        pend;

  modport master (
    output en, load, din, lzb,
    input  stac, an, bcd, frame, pend
  );

  modport slave (
    input  en, load, din, lzb,
    output stac, an, bcd, frame, pend
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of a 4-digit common-anode display. It shows each digit for DIV cycles,
// blanks for DEAD cycles, and double-buffers the BCD word so updates land on frame boundaries.
module display_scan_controller #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned DEAD  = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic                      CLK,
  input logic                      RST,
  display_scan_controller_if.slave bus
);

  localparam int unsigned DeadW = (DEAD > 1) ? $clog2(DEAD) : 1;

  typedef enum logic {StShow, StBlank} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [DeadW-1:0]   dead_q, dead_d;
  logic [1:0]         digit_q, digit_d;
  logic [15:0]        pending_q, pending_d;
  logic [15:0]        active_q, active_d;
  logic               pend_q, pend_d;
  logic [1:0]         stac_q, stac_d;
  logic [3:0]         an_q, an_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               frame_q, frame_d;

  logic               boundary;
  logic               xfer;
  logic [3:0]         nibble;
  logic               lz_blank;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dead_d    = dead_q;
    digit_d   = digit_q;
    boundary  = 1'b0;
    if (!bus.en) begin
      state_d = StShow;
      presc_d = '0;
      dead_d  = '0;
    end else begin
      unique case (state_q)
        StShow: begin
          if (presc_q == CNT_W'(DIV - 1)) begin
            presc_d = '0;
            state_d = StBlank;
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
        StBlank: begin
          if (dead_q == DeadW'(DEAD - 1)) begin
            dead_d   = '0;
            digit_d  = digit_q + 2'd1;
            state_d  = StShow;
            boundary = (digit_q == 2'd3);
          end else begin
            dead_d = dead_q + DeadW'(1);
          end
        end
        default: state_d = StShow;
      endcase
    end
  end

  // With scanning stopped there is no boundary, so a pending word is taken at once.
  always_comb begin
    xfer      = pend_q && (!bus.en || boundary);
    active_d  = xfer ? pending_q : active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (bus.load) begin
      pending_d = bus.din;
      pend_d    = 1'b1;
    end else if (xfer) begin
      pend_d = 1'b0;
    end
    frame_d = xfer;
  end

  always_comb begin
    nibble   = active_q[3:0];
    lz_blank = 1'b0;
    unique case (digit_q)
      2'd0: nibble = active_q[3:0];
      2'd1: begin
        nibble   = active_q[7:4];
        lz_blank = (active_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble   = active_q[11:8];
        lz_blank = (active_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble   = active_q[15:12];
        lz_blank = (active_q[15:12] == 4'h0);
      end
      default: nibble = active_q[3:0];
    endcase
  end

  always_comb begin
    stac_d = digit_q;
    an_d   = 4'b1111;
    bcd_d  = bcd_q;
    if (bus.en && (state_q == StShow)) begin
      bcd_d = nibble;
      if (!(bus.lzb && lz_blank)) begin
        an_d = ~(4'b0001 << digit_q);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StShow;
      presc_q   <= '0;
      dead_q    <= '0;
      digit_q   <= 2'd0;
      pending_q <= 16'h0000;
      active_q  <= 16'h0000;
      pend_q    <= 1'b0;
      stac_q    <= 2'd0;
      an_q      <= 4'b1111;
      bcd_q     <= 4'h0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dead_q    <= dead_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      stac_q    <= stac_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.stac  = stac_q;
  assign bus.an    = an_q;
  assign bus.bcd   = bcd_q;
  assign bus.frame = frame_q;
  assign bus.pend  = pend_q;

endmodule
